ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC pipeline.
- Consumes the 116-bit ID/EX bundle and computes ALU results, branch decisions and targets.
- Runs MUL as an iterative 32-cycle shift-add operation and holds the upstream stages while it does.
- Drives a registered 90-bit EX/MEM bundle to the next pipeline register.

Parameters:
- XLEN, 32, datapath width; fixed at 32 because the bundle layout depends on it.
- MUL_CYCLES, 32, iterations for the multiplier; must equal XLEN.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_ex_in  input  116  ID/EX bundle, field layout below.
- stall_out  output  1  combinational; when high, IF/ID/ID-EX hold their contents.
- ex_mem_out  output  90  registered EX/MEM bundle, field layout below.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst. Reset is sampled on the rising edge of clk only.
- id_ex_in layout:
  - [115:84] op_a
  - [83:52] op_b
  - [51:36] imm (sign-extended to 32 bits)
  - [35:20] pc
  - [19:15] rd
  - [14:11] alu_op
  - [10] use_imm
  - [9] reg_write
  - [8] mem_read
  - [7] mem_write
  - [6] branch
  - [5] valid
  - [4:0] reserved, ignored
- ex_mem_out layout:
  - [89:58] alu_result
  - [57:26] store_data (= op_b)
  - [25:21] rd
  - [20] reg_write
  - [19] mem_read
  - [18] mem_write
  - [17] br_taken
  - [16:1] br_target
  - [0] valid
- Operand selection: operand B = use_imm ? sext(imm) : op_b.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = B[4:0].
  - 8 SLT (signed), 9 SLTU; result is 1 or 0.
  - 10 MUL; result is the low 32 bits of the product.
  - 11 BEQ, 12 BNE.
  - 13-15 reserved; result 0.
- Arithmetic wraps modulo 2^32.
- Branch ops (11/12):
  - Compare op_a with op_b (never the immediate).
  - br_taken = branch & valid & condition.
  - br_target = pc + imm[15:0], 16-bit wrap.
  - alu_result = 0.
- For non-branch ops, br_taken = 0 and br_target = 0.
- Reset: state IDLE, mul counter 0, ex_mem_out = 90'b0, stall_out = 0.
- valid = 0 input: next ex_mem_out = all zeros (bubble), whatever the other fields hold.
- Non-MUL valid op: 1-cycle latency; ex_mem_out updates on the next rising edge.
- FSM states: IDLE, MUL_BUSY.
- IDLE:
  - With valid MUL at input: stall_out = 1. On the edge, latch multiplicand = op_a, multiplier = B, accumulator = 0, count = 0, control fields; go to MUL_BUSY. ex_mem_out gets a bubble.
  - Otherwise: stall_out = 0.
- MUL_BUSY, each edge:
  - If multiplier[0] = 1, accumulator += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - ex_mem_out gets a bubble.
  - stall_out = 1 while count != 31.
- At count = 31:
  - stall_out = 0.
  - On the edge, ex_mem_out gets the final accumulator with the latched rd/control fields and valid = 1; return to IDLE.
- MUL total latency: 33 rising edges from first presentation to a valid result.
- While stalled, the bench or upstream must hold id_ex_in stable. The block ignores id_ex_in changes during MUL_BUSY.
- Reset mid-MUL: abandon the operation; outputs and state return to their reset values on that edge. No partial result is ever emitted.
- Multiplying by 0 or 1 still takes the full 33 cycles; there is no early exit.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MUL FSM, stall logic and alu_op 10 behave as above.
- Undefined:
  - No FSM or multiplier registers.
  - alu_op 10 is treated as reserved: result 0, 1-cycle latency.
  - stall_out is tied to 0.

Test Plan:
- rst held 2 cycles with random id_ex_in -> ex_mem_out = 0 and stall_out = 0 throughout; first valid op afterwards completes normally.
- ADD with op_a = 32'hFFFF_FFFF, op_b = 1, use_imm = 0, rd = 3, reg_write = 1 -> next cycle alu_result = 0, rd = 3, valid = 1.
- SRA with op_a = 32'h8000_0000 and imm = 4 (use_imm = 1) -> alu_result = 32'hF800_0000. SLT with -1 vs 1 -> 1; SLTU with the same operands -> 0.
- BEQ with op_a = op_b = 7, pc = 16'h0010, imm = 16'hFFF8, branch = 1 -> br_taken = 1, br_target = 16'h0008. BNE with the same inputs -> br_taken = 0.
- MUL with op_a = 123456, op_b = 789 -> stall_out high for 32 cycles; bubbles during the operation; alu_result = 97406784 at edge 33. The following ADD issues the cycle after stall_out drops.
- MUL started, then rst asserted at count = 10 -> next edge state IDLE, ex_mem_out = 0, stall_out = 0, no result emitted. With EX_MUL_EN undefined, MUL -> result 0 after 1 cycle and stall_out never asserted.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and an optional iterative shift-add multiplier.
// Latency: 1 cycle for non-MUL ops; MUL takes 33 edges from presentation to result.
// Backpressure: stall_out holds the upstream stages while a MUL runs. Build with EX_MUL_EN for MUL.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [115:0] id_ex_in,
    output logic         stall_out,
    output logic [89:0]  ex_mem_out
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;

    // ID/EX bundle fields
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [15:0]     imm;
    logic [15:0]     pc;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            in_vld;

    assign op_a      = id_ex_in[115:84];
    assign op_b      = id_ex_in[83:52];
    assign imm       = id_ex_in[51:36];
    assign pc        = id_ex_in[35:20];
    assign rd        = id_ex_in[19:15];
    assign alu_op    = id_ex_in[14:11];
    assign use_imm   = id_ex_in[10];
    assign reg_write = id_ex_in[9];
    assign mem_read  = id_ex_in[8];
    assign mem_write = id_ex_in[7];
    assign branch    = id_ex_in[6];
    assign in_vld    = id_ex_in[5];

    // Reserved input bits and the width sanity relation are intentionally not used by logic.
    logic unused_ok;
    assign unused_ok = ^{id_ex_in[4:0], (MUL_CYCLES == XLEN)};

    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] opb_sel;
    logic [4:0]      shamt;

    assign imm_sext = {{(XLEN-16){imm[15]}}, imm};
    assign opb_sel  = use_imm ? imm_sext : op_b;
    assign shamt    = opb_sel[4:0];

    logic [XLEN-1:0] alu_res;
    logic            is_branch_op;
    logic            br_cond;

    // Single-cycle ALU and branch condition; MUL and reserved codes yield 0 here.
    always_comb begin
        alu_res      = '0;
        is_branch_op = 1'b0;
        br_cond      = 1'b0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + opb_sel;
            OP_SUB:  alu_res = op_a - opb_sel;
            OP_AND:  alu_res = op_a & opb_sel;
            OP_OR:   alu_res = op_a | opb_sel;
            OP_XOR:  alu_res = op_a ^ opb_sel;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(opb_sel))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < opb_sel)};
            OP_BEQ: begin
                is_branch_op = 1'b1;
                br_cond      = (op_a == op_b);
            end
            OP_BNE: begin
                is_branch_op = 1'b1;
                br_cond      = (op_a != op_b);
            end
            default: alu_res = '0;
        endcase
    end

    logic        br_taken;
    logic [15:0] br_target;
    logic [89:0] single_out;

    assign br_taken   = is_branch_op & branch & in_vld & br_cond;
    assign br_target  = is_branch_op ? (pc + imm) : 16'h0000;
    assign single_out = in_vld ? {alu_res, op_b, rd, reg_write, mem_read, mem_write,
                                  br_taken, br_target, 1'b1}
                               : 90'b0;

    logic [89:0] ex_mem_d;
    logic [89:0] ex_mem_q;

    assign ex_mem_out = ex_mem_q;

`ifdef EX_MUL_EN
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MUL_BUSY = 1'b1;

    logic [0:0]      state_d,  state_q;
    logic [XLEN-1:0] mcand_d,  mcand_q;
    logic [XLEN-1:0] mplier_d, mplier_q;
    logic [XLEN-1:0] acc_d,    acc_q;
    logic [4:0]      cnt_d,    cnt_q;
    logic [XLEN-1:0] sd_d,     sd_q;
    logic [4:0]      rd_d,     rd_q;
    logic            rw_d,     rw_q;
    logic            mr_d,     mr_q;
    logic            mw_d,     mw_q;

    logic            mul_start;
    logic            mul_last;
    logic [XLEN-1:0] acc_step;

    assign mul_start = (state_q == S_IDLE) & in_vld & (alu_op == OP_MUL);
    assign mul_last  = (cnt_q == 5'(MUL_CYCLES - 1));
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Upstream hold: from MUL presentation until the final iteration is underway.
    assign stall_out = ~rst & (mul_start | ((state_q == S_MUL_BUSY) & ~mul_last));

    // Next-state for the multiplier FSM, its datapath and the output bundle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sd_d     = sd_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        ex_mem_d = 90'b0;
        if (state_q == S_IDLE) begin
            if (mul_start) begin
                state_d  = S_MUL_BUSY;
                mcand_d  = op_a;
                mplier_d = opb_sel;
                acc_d    = '0;
                cnt_d    = 5'd0;
                sd_d     = op_b;
                rd_d     = rd;
                rw_d     = reg_write;
                mr_d     = mem_read;
                mw_d     = mem_write;
            end else begin
                ex_mem_d = single_out;
            end
        end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (mul_last) begin
                state_d  = S_IDLE;
                cnt_d    = 5'd0;
                ex_mem_d = {acc_step, sd_q, rd_q, rw_q, mr_q, mw_q, 1'b0, 16'h0000, 1'b1};
            end
        end
    end

    // State and EX/MEM registers; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            sd_q     <= '0;
            rd_q     <= 5'd0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            ex_mem_q <= 90'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sd_q     <= sd_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            ex_mem_q <= ex_mem_d;
        end
    end
`else
    // Without the multiplier every op, including code 10, completes in one cycle.
    assign stall_out = 1'b0;

    // Next EX/MEM bundle straight from the single-cycle path.
    always_comb begin
        ex_mem_d = single_out;
    end

    // EX/MEM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= 90'b0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected bundles, a monitor pops on valid output.
// Works in both builds; MUL expectations depend on EX_MUL_EN.
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [115:0] id_ex_in;
    logic         stall_out;
    logic [89:0]  ex_mem_out;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    logic [89:0] exp_q[$];
    int          id_q[$];

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .id_ex_in   (id_ex_in),
        .stall_out  (stall_out),
        .ex_mem_out (ex_mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [115:0] mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [15:0] im, input logic [15:0] p,
                                        input logic [4:0] r, input logic [3:0] op,
                                        input logic ui, input logic rw, input logic mr,
                                        input logic mw, input logic br, input logic v);
        return {a, b, im, p, r, op, ui, rw, mr, mw, br, v, 5'b0};
    endfunction

    function automatic logic [89:0] mo(input logic [31:0] res, input logic [31:0] sd,
                                       input logic [4:0] r, input logic rw, input logic mr,
                                       input logic mw, input logic bt, input logic [15:0] tg);
        return {res, sd, r, rw, mr, mw, bt, tg, 1'b1};
    endfunction

    function automatic logic [31:0] mul_exp(input logic [31:0] prod);
`ifdef EX_MUL_EN
        return prod;
`else
        return 32'h0 & prod;
`endif
    endfunction

    task automatic chk(input string nm, input logic [89:0] act, input logic [89:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Present one non-MUL vector for a single cycle.
    task automatic issue(input logic [115:0] v, input logic [89:0] e, input int id);
        id_ex_in = v;
        if (v[5]) begin
            exp_q.push_back(e);
            id_q.push_back(id);
        end
        #1;
        chk($sformatf("stall_vec%0d", id), {89'b0, stall_out}, 90'b0);
        @(posedge clk);
        #1;
        if (!v[5]) chk($sformatf("bubble_vec%0d", id), ex_mem_out, 90'b0);
    endtask

    // Present a MUL and hold it while stall_out is high.
    task automatic run_mul(input logic [115:0] v, input logic [89:0] e, input int id);
        int n;
        n = 0;
        id_ex_in = v;
        exp_q.push_back(e);
        id_q.push_back(id);
        #1;
`ifdef EX_MUL_EN
        while (stall_out && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            chk($sformatf("mul_bubble_vec%0d", id), ex_mem_out, 90'b0);
        end
        chk($sformatf("mul_stall_cycles_vec%0d", id), 90'(n), 90'd32);
        @(posedge clk);
        #1;
`else
        chk($sformatf("mul_nostall_vec%0d", id), {89'b0, stall_out}, 90'b0);
        @(posedge clk);
        #1;
`endif
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && ex_mem_out[0]) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output act=%h exp=none", ex_mem_out);
            end else begin
                logic [89:0] e;
                int          id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                if (ex_mem_out !== e) begin
                    bad++;
                    $display("FAIL vec%0d act=%h exp=%h", id, ex_mem_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [115:0] rv;
        rst = 1'b1;
        // Reset with random inputs; second cycle forces a valid MUL to exercise stall gating.
        for (int i = 0; i < 2; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            if (i == 1) begin
                rv[14:11] = 4'd10;
                rv[5]     = 1'b1;
            end
            id_ex_in = rv;
            #1;
            chk("rst_stall_pre", {89'b0, stall_out}, 90'b0);
            @(posedge clk);
            #1;
            chk("rst_out", ex_mem_out, 90'b0);
            chk("rst_stall", {89'b0, stall_out}, 90'b0);
        end
        id_ex_in = '0;
        rst      = 1'b0;
        mon_en   = 1'b1;

        //          a             b             imm       pc        rd  op  ui rw mr mw br v
        issue(mk(32'hFFFF_FFFF, 32'd1,        16'h0000, 16'h0000, 5'd3, 4'd0,  0, 1, 0, 0, 0, 1),
              mo(32'h0, 32'd1, 5'd3, 1, 0, 0, 0, 16'h0000), 1);
        issue(mk(32'h8000_0000, 32'h55,       16'h0004, 16'h0000, 5'd5, 4'd7,  1, 1, 0, 0, 0, 1),
              mo(32'hF800_0000, 32'h55, 5'd5, 1, 0, 0, 0, 16'h0000), 2);
        issue(mk(32'hFFFF_FFFF, 32'd1,        16'h0000, 16'h0000, 5'd6, 4'd8,  0, 1, 0, 0, 0, 1),
              mo(32'd1, 32'd1, 5'd6, 1, 0, 0, 0, 16'h0000), 3);
        issue(mk(32'hFFFF_FFFF, 32'd1,        16'h0000, 16'h0000, 5'd6, 4'd9,  0, 1, 0, 0, 0, 1),
              mo(32'd0, 32'd1, 5'd6, 1, 0, 0, 0, 16'h0000), 4);
        issue(mk(32'd7,         32'd7,        16'hFFF8, 16'h0010, 5'd0, 4'd11, 0, 0, 0, 0, 1, 1),
              mo(32'd0, 32'd7, 5'd0, 0, 0, 0, 1, 16'h0008), 5);
        issue(mk(32'd7,         32'd7,        16'hFFF8, 16'h0010, 5'd0, 4'd12, 0, 0, 0, 0, 1, 1),
              mo(32'd0, 32'd7, 5'd0, 0, 0, 0, 0, 16'h0008), 6);
        issue(mk(32'd5,         32'd7,        16'h0000, 16'h0000, 5'd1, 4'd1,  0, 1, 0, 0, 0, 1),
              mo(32'hFFFF_FFFE, 32'd7, 5'd1, 1, 0, 0, 0, 16'h0000), 7);
        issue(mk(32'hF0F0_1234, 32'h0FF0_FF00, 16'h0000, 16'h0000, 5'd2, 4'd2, 0, 1, 0, 0, 0, 1),
              mo(32'h00F0_1200, 32'h0FF0_FF00, 5'd2, 1, 0, 0, 0, 16'h0000), 8);
        issue(mk(32'hF0F0_1234, 32'h0FF0_FF00, 16'h0000, 16'h0000, 5'd2, 4'd3, 0, 1, 0, 0, 0, 1),
              mo(32'hFFF0_FF34, 32'h0FF0_FF00, 5'd2, 1, 0, 0, 0, 16'h0000), 9);
        issue(mk(32'hF0F0_1234, 32'h0FF0_FF00, 16'h0000, 16'h0000, 5'd2, 4'd4, 0, 1, 0, 0, 0, 1),
              mo(32'hFF00_ED34, 32'h0FF0_FF00, 5'd2, 1, 0, 0, 0, 16'h0000), 10);
        issue(mk(32'd1,         32'd33,       16'h0000, 16'h0000, 5'd4, 4'd5,  0, 1, 0, 0, 0, 1),
              mo(32'd2, 32'd33, 5'd4, 1, 0, 0, 0, 16'h0000), 11);
        issue(mk(32'h8000_0000, 32'd0,        16'h0004, 16'h0000, 5'd4, 4'd6,  1, 1, 0, 0, 0, 1),
              mo(32'h0800_0000, 32'd0, 5'd4, 1, 0, 0, 0, 16'h0000), 12);
        issue(mk(32'd10,        32'hDEAD_BEEF, 16'hFFFE, 16'h0000, 5'd7, 4'd0, 1, 1, 1, 0, 0, 1),
              mo(32'd8, 32'hDEAD_BEEF, 5'd7, 1, 1, 0, 0, 16'h0000), 13);
        issue(mk(32'd100,       32'hCAFE_F00D, 16'h0004, 16'h0000, 5'd0, 4'd0, 1, 0, 0, 1, 0, 1),
              mo(32'd104, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 0, 16'h0000), 14);
        issue(mk(32'h1234_5678, 32'h9ABC_DEF0, 16'h1111, 16'h2222, 5'd9, 4'd13, 0, 1, 0, 0, 1, 1),
              mo(32'd0, 32'h9ABC_DEF0, 5'd9, 1, 0, 0, 0, 16'h0000), 15);
        issue(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 5'd31, 4'd0, 1, 1, 1, 1, 1, 0),
              90'b0, 16);
        issue(mk(32'd9,         32'd9,        16'h0010, 16'h1234, 5'd0, 4'd11, 0, 0, 0, 0, 0, 1),
              mo(32'd0, 32'd9, 5'd0, 0, 0, 0, 0, 16'h1244), 17);
        issue(mk(32'd1,         32'd2,        16'h0020, 16'hFFF0, 5'd0, 4'd12, 0, 0, 0, 0, 1, 1),
              mo(32'd0, 32'd2, 5'd0, 0, 0, 0, 1, 16'h0010), 18);
        issue(mk(32'd5,         32'd5,        16'h0009, 16'h0000, 5'd0, 4'd11, 1, 0, 0, 0, 1, 1),
              mo(32'd0, 32'd5, 5'd0, 0, 0, 0, 1, 16'h0009), 19);
        issue(mk(32'd3,         32'd0,        16'hFFFF, 16'h0000, 5'd8, 4'd8,  1, 1, 0, 0, 0, 1),
              mo(32'd0, 32'd0, 5'd8, 1, 0, 0, 0, 16'h0000), 20);
        issue(mk(32'd3,         32'd0,        16'hFFFF, 16'h0000, 5'd8, 4'd9,  1, 1, 0, 0, 0, 1),
              mo(32'd1, 32'd0, 5'd8, 1, 0, 0, 0, 16'h0000), 21);

        // Multiplies, each followed immediately by an ADD.
        run_mul(mk(32'd123456, 32'd789, 16'h0000, 16'h0000, 5'd9, 4'd10, 0, 1, 0, 0, 0, 1),
                mo(mul_exp(32'd97406784), 32'd789, 5'd9, 1, 0, 0, 0, 16'h0000), 30);
        issue(mk(32'd2, 32'd3, 16'h0000, 16'h0000, 5'd10, 4'd0, 0, 1, 0, 0, 0, 1),
              mo(32'd5, 32'd3, 5'd10, 1, 0, 0, 0, 16'h0000), 31);
        run_mul(mk(32'd7, 32'd0, 16'hFFFD, 16'h0000, 5'd11, 4'd10, 1, 1, 0, 0, 0, 1),
                mo(mul_exp(32'hFFFF_FFEB), 32'd0, 5'd11, 1, 0, 0, 0, 16'h0000), 32);
        run_mul(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 5'd12, 4'd10, 0, 1, 0, 0, 0, 1),
                mo(mul_exp(32'd1), 32'hFFFF_FFFF, 5'd12, 1, 0, 0, 0, 16'h0000), 33);

`ifdef EX_MUL_EN
        // Reset while the multiplier counter reads 10: nothing may be emitted.
        id_ex_in = mk(32'd123456, 32'd789, 16'h0000, 16'h0000, 5'd13, 4'd10, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midmul_stall_before_rst", {89'b0, stall_out}, 90'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midmul_rst_out", ex_mem_out, 90'b0);
        chk("midmul_rst_stall", {89'b0, stall_out}, 90'b0);
        id_ex_in = '0;
        rst      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midmul_quiet", ex_mem_out, 90'b0);
`endif
        issue(mk(32'd40, 32'd2, 16'h0000, 16'h0000, 5'd14, 4'd0, 0, 1, 0, 0, 0, 1),
              mo(32'd42, 32'd2, 5'd14, 1, 0, 0, 0, 16'h0000), 40);

        id_ex_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_outputs act=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
